uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver with an AXI-Stream style output.
//
// Frame: one start bit (low), DATA_WIDTH data bits (LSB first), one stop bit
// (high). Each bit is sampled once at its midpoint. One bit period lasts
// 8*prescale clocks. The prescale value is captured at the start edge, so it
// may change mid-frame without effect.
//
// Ports
//   clk_i          system clock
//   rstn_i         asynchronous active-low reset
//   rxd            serial line, asynchronous, idles high
//   prescale       clocks per 1/8 bit (0 treated as 1)
//   m_axis_tdata   received word, LSB = first bit on the line
//   m_axis_tvalid  tdata holds an unconsumed word
//   m_axis_tready  downstream accepts the word
//   busy           receiver is inside a frame (any state but IDLE)
//   overrun_error  1-cycle pulse: a new word overwrote an unconsumed one
//   frame_error    1-cycle pulse: stop bit sampled low
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  rxd,
   input  logic [15:0]           prescale,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  busy,
   output logic                  overrun_error,
   output logic                  frame_error
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t                state_q, state_d;
   logic                  sync1_q, sync2_q;
   logic                  rx;
   // 19 bits hold 8*65535-1 without wrapping.
   logic [18:0]           cnt_q, cnt_d;
   logic [15:0]           p_q, p_d;
   logic [3:0]            bits_q, bits_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  done_q, done_d;
   logic                  ferr_d;

   logic [15:0]           p_eff;
   logic [18:0]           half_load;
   logic [18:0]           bit_load;
   logic                  cnt_zero;

   assign rx        = sync2_q;
   assign p_eff     = (prescale == 16'd0) ? 16'd1 : prescale;
   // Half a bit (4*p-1) from the detected edge lands on the start-bit middle.
   assign half_load = {1'b0, p_eff, 2'b00} - 19'd1;
   assign bit_load  = {p_q, 3'b000} - 19'd1;
   assign cnt_zero  = (cnt_q == 19'd0);
   assign busy      = (state_q != IDLE);

   // Two-flop synchronizer; resets to the idle line level so reset release
   // never looks like a start edge unless the line really is low.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make sync2_q take the old sync1_q,
         // giving two real flop stages; blocking would collapse them into one.
         sync1_q <= rxd;
         sync2_q <= sync1_q;
      end
   end

   // Next-state and datapath logic.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      bits_d  = bits_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!rx) begin
               p_d     = p_eff;
               cnt_d   = half_load;
               state_d = START;
            end
         end

         START: begin
            if (cnt_zero) begin
               if (!rx) begin
                  cnt_d   = bit_load;
                  bits_d  = 4'd0;
                  state_d = DATA;
               end else begin
                  // Line went back high before mid start bit: glitch.
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end

         DATA: begin
            if (cnt_zero) begin
               shift_d = {rx, shift_q[DATA_WIDTH-1:1]};
               cnt_d   = bit_load;
               if (bits_q == 4'(DATA_WIDTH - 1)) begin
                  state_d = STOP;
               end else begin
                  bits_d = bits_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end

         STOP: begin
            if (cnt_zero) begin
               // IDLE is re-entered at mid stop bit so back-to-back frames
               // have half a bit of slack to catch the next start edge.
               if (rx) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end

         WAIT_IDLE: begin
            // A held-low break reports once, then waits for the line to idle.
            if (rx) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         p_q     <= 16'd1;
         bits_q  <= '0;
         shift_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         bits_q  <= bits_d;
         shift_q <= shift_d;
         done_q  <= done_d;
      end
   end

   // Output stage. A completed word always lands; it is an overrun only if
   // the previous word is still pending and not being accepted this cycle.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         overrun_error <= 1'b0;
         frame_error   <= 1'b0;
      end else begin
         frame_error   <= ferr_d;
         overrun_error <= 1'b0;
         if (done_q) begin
            m_axis_tdata  <= shift_q;
            m_axis_tvalid <= 1'b1;
            overrun_error <= m_axis_tvalid && !m_axis_tready;
         end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed testbench for uart_rx (DATA_WIDTH = 8).
// Inputs change on the falling clock edge; a recorder process samples the DUT
// 1 ns after each falling edge and logs accepted words, tvalid rises and
// error pulses. Each test task compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        rstn;
   logic        rxd;
   logic [15:0] prescale;
   logic [7:0]  tdata;
   logic        tvalid;
   logic        tready;
   logic        busy;
   logic        overrun_error;
   logic        frame_error;

   int checks = 0;
   int errors = 0;

   uart_rx #(.DATA_WIDTH(8)) dut (
      .clk_i         (clk),
      .rstn_i        (rstn),
      .rxd           (rxd),
      .prescale      (prescale),
      .m_axis_tdata  (tdata),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .busy          (busy),
      .overrun_error (overrun_error),
      .frame_error   (frame_error)
   );

   always #5 clk = ~clk;

   // ---------------- recorder ----------------
   int         cyc = 0;
   logic       prev_valid = 1'b0;
   int         rise_cnt = 0;
   int         last_rise = 0;
   int         valid_cycles = 0;
   int         ovr_cnt = 0;
   int         ferr_cnt = 0;
   logic [7:0] words[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      #1;
      if (tvalid && !prev_valid) begin
         rise_cnt  = rise_cnt + 1;
         last_rise = cyc;
      end
      prev_valid = tvalid;
      if (tvalid) valid_cycles = valid_cycles + 1;
      if (tvalid && tready) words.push_back(tdata);
      if (overrun_error) ovr_cnt = ovr_cnt + 1;
      if (frame_error) ferr_cnt = ferr_cnt + 1;
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_frame(input logic [7:0] d, input int pe, input logic stop_bit);
      rxd = 1'b0;
      repeat (8 * pe) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         repeat (8 * pe) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (8 * pe) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rstn     = 1'b0;
      rxd      = 1'b0;
      tready   = 1'b0;
      prescale = 16'd1;
      repeat (4) @(negedge clk);
      checks++;
      if (tvalid !== 1'b0 || tdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_out: tvalid=%b tdata=%h, want 0/00", tvalid, tdata);
      end
      checks++;
      if (busy !== 1'b0 || overrun_error !== 1'b0 || frame_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: busy=%b ovr=%b ferr=%b, want 0", busy, overrun_error, frame_error);
      end
      rxd  = 1'b1;
      rstn = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b, want 0", busy);
      end
   endtask

   // Single frames with tready=1; latency is 76*p+3 cycles from the first
   // edge that sees rxd low (prescale 0 behaves as 1).
   task automatic test_single();
      logic [7:0] data_v [3] = '{8'h55, 8'h55, 8'hC6};
      int         pre_v  [3] = '{1, 0, 3};
      int         lat_v  [3] = '{79, 79, 231};
      int         pe_v   [3] = '{1, 1, 3};
      for (int t = 0; t < 3; t++) begin
         int start, base_w, base_r, base_v, base_o, base_f;
         tready   = 1'b1;
         prescale = 16'(pre_v[t]);
         repeat (4) @(negedge clk);
         base_w = words.size();
         base_r = rise_cnt;
         base_v = valid_cycles;
         base_o = ovr_cnt;
         base_f = ferr_cnt;
         start  = cyc;
         send_frame(data_v[t], pe_v[t], 1'b1);
         repeat (6) @(negedge clk);
         checks++;
         if (rise_cnt - base_r != 1) begin
            errors++;
            $display("FAIL single%0d_rises: got %0d, want 1", t, rise_cnt - base_r);
         end else begin
            checks++;
            if (last_rise - start - 1 != lat_v[t]) begin
               errors++;
               $display("FAIL single%0d_latency: got %0d, want %0d", t, last_rise - start - 1, lat_v[t]);
            end
         end
         checks++;
         if (words.size() - base_w != 1) begin
            errors++;
            $display("FAIL single%0d_count: got %0d words, want 1", t, words.size() - base_w);
         end else begin
            checks++;
            if (words[base_w] !== data_v[t]) begin
               errors++;
               $display("FAIL single%0d_data: got %h, want %h", t, words[base_w], data_v[t]);
            end
         end
         checks++;
         if (valid_cycles - base_v != 1) begin
            errors++;
            $display("FAIL single%0d_valid_width: got %0d cycles, want 1", t, valid_cycles - base_v);
         end
         checks++;
         if (ovr_cnt != base_o || ferr_cnt != base_f) begin
            errors++;
            $display("FAIL single%0d_errors: ovr=%0d ferr=%0d, want 0/0", t, ovr_cnt - base_o, ferr_cnt - base_f);
         end
      end
   endtask

   task automatic test_back_to_back();
      int base_o, base_f, base_w;
      tready   = 1'b0;
      prescale = 16'd4;
      repeat (4) @(negedge clk);
      base_o = ovr_cnt;
      base_f = ferr_cnt;
      base_w = words.size();
      send_frame(8'hA3, 4, 1'b1);
      checks++;
      if (tvalid !== 1'b1 || tdata !== 8'hA3) begin
         errors++;
         $display("FAIL b2b_first: tvalid=%b tdata=%h, want 1/a3", tvalid, tdata);
      end
      send_frame(8'h0F, 4, 1'b1);
      repeat (4) @(negedge clk);
      checks++;
      if (tvalid !== 1'b1 || tdata !== 8'h0F) begin
         errors++;
         $display("FAIL b2b_second: tvalid=%b tdata=%h, want 1/0f", tvalid, tdata);
      end
      checks++;
      if (ovr_cnt - base_o != 1) begin
         errors++;
         $display("FAIL b2b_overrun: got %0d pulse-cycles, want 1", ovr_cnt - base_o);
      end
      checks++;
      if (ferr_cnt != base_f) begin
         errors++;
         $display("FAIL b2b_ferr: got %0d, want 0", ferr_cnt - base_f);
      end
      tready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (tvalid !== 1'b0 || words.size() - base_w != 1) begin
         errors++;
         $display("FAIL b2b_drain: tvalid=%b words=%0d, want 0/1", tvalid, words.size() - base_w);
      end else begin
         checks++;
         if (words[base_w] !== 8'h0F) begin
            errors++;
            $display("FAIL b2b_drain_data: got %h, want 0f", words[base_w]);
         end
      end
   endtask

   task automatic test_frame_error();
      int base_r, base_f, base_o;
      tready   = 1'b1;
      prescale = 16'd2;
      repeat (4) @(negedge clk);
      base_r = rise_cnt;
      base_f = ferr_cnt;
      base_o = ovr_cnt;
      send_frame(8'hFF, 2, 1'b0);
      repeat (200) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL ferr_busy_break: busy=%b, want 1", busy);
      end
      rxd = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL ferr_busy_release: busy=%b, want 0", busy);
      end
      checks++;
      if (ferr_cnt - base_f != 1) begin
         errors++;
         $display("FAIL ferr_count: got %0d pulse-cycles, want 1", ferr_cnt - base_f);
      end
      checks++;
      if (rise_cnt != base_r || ovr_cnt != base_o) begin
         errors++;
         $display("FAIL ferr_no_word: rises=%0d ovr=%0d, want 0/0", rise_cnt - base_r, ovr_cnt - base_o);
      end
   endtask

   task automatic test_glitch();
      int base_r, base_f, base_o;
      prescale = 16'd2;
      repeat (4) @(negedge clk);
      base_r = rise_cnt;
      base_f = ferr_cnt;
      base_o = ovr_cnt;
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL glitch_detect: busy=%b, want 1", busy);
      end
      repeat (30) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch_idle: busy=%b, want 0", busy);
      end
      checks++;
      if (rise_cnt != base_r || ferr_cnt != base_f || ovr_cnt != base_o) begin
         errors++;
         $display("FAIL glitch_quiet: rises=%0d ferr=%0d ovr=%0d, want 0/0/0",
                  rise_cnt - base_r, ferr_cnt - base_f, ovr_cnt - base_o);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      int         base_w;
      d        = 8'h3C;
      tready   = 1'b1;
      prescale = 16'd1;
      repeat (4) @(negedge clk);
      base_w = words.size();
      rxd = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rxd = d[i];
         repeat (8) @(negedge clk);
      end
      rxd = d[4];
      repeat (4) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || tvalid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_abort: busy=%b tvalid=%b, want 0/0", busy, tvalid);
      end
      repeat (3) @(negedge clk);
      rxd  = 1'b1;
      rstn = 1'b1;
      repeat (20) @(negedge clk);
      send_frame(8'h81, 1, 1'b1);
      repeat (6) @(negedge clk);
      checks++;
      if (words.size() - base_w != 1) begin
         errors++;
         $display("FAIL midreset_count: got %0d words, want 1", words.size() - base_w);
      end else begin
         checks++;
         if (words[base_w] !== 8'h81) begin
            errors++;
            $display("FAIL midreset_data: got %h, want 81", words[base_w]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_frame_error();
      test_glitch();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
